// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches over a req/ack memory handshake
// and holds each instruction until the downstream datapath retires it.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        ImemReq,
    output logic [31:0] ImemAddr,
    input  logic        ImemAck,
    input  logic [31:0] ImemRdata,
    output logic [31:0] Instr,
    output logic        InstrValid,
    input  logic        Stall,
    input  logic        PCSrc,
    input  logic [31:0] Result,
    output logic [31:0] PC,
    output logic [31:0] PCPlus8
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_VALID = 2'd2
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic        r_req;
    logic        r_valid;

    logic [31:0] w_pc_plus4;
    logic [31:0] w_redirect;
    logic        w_unused_result_bits;

    assign w_pc_plus4 = r_pc + 32'd4;
    // Low result bits are dropped so the PC can never become misaligned.
    assign w_redirect = {Result[31:2], 2'b00};
    assign w_unused_result_bits = ^Result[1:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_pc    <= RESET_PC;
            r_instr <= 32'h0;
            r_req   <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_state <= S_FETCH;
                    r_req   <= 1'b1;
                end
                S_FETCH: begin
                    if (ImemAck) begin
                        r_instr <= ImemRdata;
                        r_valid <= 1'b1;
                        r_req   <= 1'b0;
                        r_state <= S_VALID;
                    end
                end
                S_VALID: begin
                    // PCSrc/Result only matter on the edge the instruction retires.
                    if (!Stall) begin
                        r_pc    <= PCSrc ? w_redirect : w_pc_plus4;
                        r_valid <= 1'b0;
                        r_req   <= 1'b1;
                        r_state <= S_FETCH;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_req   <= 1'b0;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign ImemReq    = r_req;
    assign ImemAddr   = r_pc;
    assign Instr      = r_instr;
    assign InstrValid = r_valid;
    assign PC         = r_pc;
    assign PCPlus8    = r_pc + 32'd8;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios with literal expectations plus a
// randomized run, all cross-checked every cycle against a behavioural model.
module tb_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset     = 1'b0;
    logic        ImemAck   = 1'b0;
    logic [31:0] ImemRdata = 32'h0;
    logic        Stall     = 1'b0;
    logic        PCSrc     = 1'b0;
    logic [31:0] Result    = 32'h0;

    logic        ImemReq;
    logic [31:0] ImemAddr;
    logic [31:0] Instr;
    logic        InstrValid;
    logic [31:0] PC;
    logic [31:0] PCPlus8;

    fetch_unit #(.RESET_PC(RST_PC)) u_dut (
        .clk        (clk),
        .reset      (reset),
        .ImemReq    (ImemReq),
        .ImemAddr   (ImemAddr),
        .ImemAck    (ImemAck),
        .ImemRdata  (ImemRdata),
        .Instr      (Instr),
        .InstrValid (InstrValid),
        .Stall      (Stall),
        .PCSrc      (PCSrc),
        .Result     (Result),
        .PC         (PC),
        .PCPlus8    (PCPlus8)
    );

    // Second instance at the top of the address space, with zero-wait memory.
    logic        wrap_rst = 1'b0;
    logic        w_req;
    logic [31:0] w_addr;
    logic [31:0] w_instr;
    logic        w_valid;
    logic [31:0] w_pc;
    logic [31:0] w_pc8;

    fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clk        (clk),
        .reset      (wrap_rst),
        .ImemReq    (w_req),
        .ImemAddr   (w_addr),
        .ImemAck    (w_req),
        .ImemRdata  (32'hE1A0_0000),
        .Instr      (w_instr),
        .InstrValid (w_valid),
        .Stall      (1'b0),
        .PCSrc      (1'b0),
        .Result     (32'h0),
        .PC         (w_pc),
        .PCPlus8    (w_pc8)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hE3A0_1005;
    endfunction

    // Behavioural model: one instruction in flight, tracked as flags.
    bit          m_idle  = 1'b1;
    logic        m_req   = 1'b0;
    logic        m_valid = 1'b0;
    logic [31:0] m_pc    = RST_PC;
    logic [31:0] m_instr = 32'h0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_idle  = 1'b1;
            m_req   = 1'b0;
            m_valid = 1'b0;
            m_pc    = RST_PC;
            m_instr = 32'h0;
        end else if (m_idle) begin
            m_idle = 1'b0;
            m_req  = 1'b1;
        end else if (m_req) begin
            if (ImemAck) begin
                m_instr = ImemRdata;
                m_valid = 1'b1;
                m_req   = 1'b0;
            end
        end else if (m_valid && !Stall) begin
            m_pc    = PCSrc ? (Result & 32'hFFFF_FFFC) : m_pc + 32'd4;
            m_valid = 1'b0;
            m_req   = 1'b1;
        end
    end

    // Per-cycle comparison, 1 time unit after the edge; stimulus changes at +2.
    always @(posedge clk) begin
        #1;
        chk("m.ImemReq",    {31'b0, ImemReq},    {31'b0, m_req});
        chk("m.ImemAddr",   ImemAddr,            m_pc);
        chk("m.Instr",      Instr,               m_instr);
        chk("m.InstrValid", {31'b0, InstrValid}, {31'b0, m_valid});
        chk("m.PC",         PC,                  m_pc);
        chk("m.PCPlus8",    PCPlus8,             m_pc + 32'd8);
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        tick();
        tick();
        // Reset values
        chk("rst.ImemReq",    {31'b0, ImemReq},    32'd0);
        chk("rst.ImemAddr",   ImemAddr,            32'h0);
        chk("rst.Instr",      Instr,               32'h0);
        chk("rst.InstrValid", {31'b0, InstrValid}, 32'd0);
        chk("rst.PCPlus8",    PCPlus8,             32'h8);
        chk("wrap.rstPC8",    w_pc8,               32'h0000_0004);
        chk("wrap.rstAddr",   w_addr,              32'hFFFF_FFFC);

        // Wrap-around instance
        wrap_rst = 1'b1;
        tick();
        chk("wrap.req1",   {31'b0, w_req},   32'd1);
        chk("wrap.addr1",  w_addr,           32'hFFFF_FFFC);
        tick();
        chk("wrap.valid",  {31'b0, w_valid}, 32'd1);
        chk("wrap.instr",  w_instr,          32'hE1A0_0000);
        tick();
        chk("wrap.addr2",  w_addr,           32'h0000_0000);
        chk("wrap.req2",   {31'b0, w_req},   32'd1);
        chk("wrap.pc8",    w_pc8,            32'h0000_0008);

        // First fetch with zero-wait memory
        reset = 1'b1;
        tick();
        chk("first.req",  {31'b0, ImemReq},    32'd1);
        chk("first.addr", ImemAddr,            32'h0);
        ImemAck   = 1'b1;
        ImemRdata = mem_word(32'h0);
        tick();
        ImemAck = 1'b0;
        chk("first.instr", Instr,               32'hE3A0_1005);
        chk("first.valid", {31'b0, InstrValid}, 32'd1);
        chk("first.pc",    PC,                  32'h0);
        chk("first.pc8",   PCPlus8,             32'h8);
        chk("first.reqlo", {31'b0, ImemReq},    32'd0);
        tick();
        chk("seq.addr4",  ImemAddr,            32'h4);
        chk("seq.valid0", {31'b0, InstrValid}, 32'd0);
        ImemAck   = 1'b1;
        ImemRdata = mem_word(32'h4);
        tick();
        ImemAck = 1'b0;
        chk("seq.pc4", PC, 32'h4);

        // Branch on retirement of the instruction at 4
        PCSrc  = 1'b1;
        Result = 32'h0000_0103;
        tick();
        PCSrc  = 1'b0;
        Result = 32'h0;
        chk("br.addr", ImemAddr,         32'h0000_0100);
        chk("br.req",  {31'b0, ImemReq}, 32'd1);

        // Memory wait states: address held stable
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("wait.addr", ImemAddr,         32'h0000_0100);
            chk("wait.req",  {31'b0, ImemReq}, 32'd1);
        end
        ImemAck   = 1'b1;
        ImemRdata = mem_word(32'h100);
        tick();
        ImemAck = 1'b0;
        chk("wait.instr", Instr, mem_word(32'h100));

        // Stall with PCSrc toggling
        Stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            PCSrc  = i[0];
            Result = $urandom;
            tick();
            chk("stall.pc",    PC,                  32'h0000_0100);
            chk("stall.instr", Instr,               mem_word(32'h100));
            chk("stall.valid", {31'b0, InstrValid}, 32'd1);
        end
        Stall = 1'b0;
        PCSrc = 1'b0;
        tick();
        chk("stall.next", PC, 32'h0000_0104);

        // Reset, run to FETCH at 8, then reset mid-fetch
        reset = 1'b0;
        #1;
        chk("rst2.req", {31'b0, ImemReq}, 32'd0);
        chk("rst2.pc",  PC,               RST_PC);
        tick();
        reset = 1'b1;
        for (int k = 0; k < 2; k++) begin
            tick();
            chk("seq.addr",  ImemAddr,            32'(4 * k));
            chk("seq.vlow",  {31'b0, InstrValid}, 32'd0);
            ImemAck   = 1'b1;
            ImemRdata = mem_word(32'(4 * k));
            tick();
            ImemAck = 1'b0;
            chk("seq.vhigh", {31'b0, InstrValid}, 32'd1);
            chk("seq.instr", Instr,               mem_word(32'(4 * k)));
        end
        tick();
        chk("mid.addr8", ImemAddr,         32'h8);
        chk("mid.req",   {31'b0, ImemReq}, 32'd1);
        reset = 1'b0;
        #1;
        chk("mid.reqdrop", {31'b0, ImemReq},    32'd0);
        chk("mid.addrrst", ImemAddr,            RST_PC);
        chk("mid.valid",   {31'b0, InstrValid}, 32'd0);
        tick();
        reset     = 1'b1;
        ImemAck   = 1'b1;
        ImemRdata = 32'hDEAD_BEEF;
        tick();
        ImemAck = 1'b0;
        chk("stray.valid", {31'b0, InstrValid}, 32'd0);
        chk("stray.instr", Instr,               32'h0);
        chk("stray.req",   {31'b0, ImemReq},    32'd1);
        chk("stray.addr",  ImemAddr,            RST_PC);

        // Randomized run, checked by the model every cycle
        for (int c = 0; c < 3000; c++) begin
            tick();
            ImemAck   = ($urandom_range(0, 2) != 0);
            ImemRdata = $urandom;
            Stall     = ($urandom_range(0, 3) == 0);
            PCSrc     = ($urandom_range(0, 3) == 0);
            Result    = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF - 32'($urandom_range(0, 7)) : $urandom;
            reset     = ($urandom_range(0, 149) != 0);
        end
        reset = 1'b1;
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
